// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial frame deserializer.
package serial_frame_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

endpackage

// File: rtl/serial_frame_deserializer.sv
// Deserializes start/payload/parity/stop frames from a qualified serial bit stream
// into words, pulsing word_wr on good frames and an error pulse on dropped ones.
module serial_frame_deserializer
    import serial_frame_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  bit_in,
    input  logic                  bit_vld,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_wr,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    state_e                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    par_rx_r;
    logic [DATA_WIDTH-1:0]   word_r;
    logic                    word_wr_r;
    logic                    parity_err_r;
    logic                    frame_err_r;

    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] data);
        expected_parity = (^data) ^ (PARITY_ODD != 0);
    endfunction

    // Frame FSM, payload capture and registered result pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            shift_r      <= '0;
            par_rx_r     <= 1'b0;
            word_r       <= '0;
            word_wr_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            word_wr_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (bit_vld) begin
                case (state_r)
                    IDLE: begin
                        if (!bit_in) begin
                            state_r <= DATA;
                            cnt_r   <= '0;
                        end
                    end
                    DATA: begin
                        shift_r[cnt_r] <= bit_in;
                        if (cnt_r == LAST_IDX) begin
                            cnt_r   <= '0;
                            state_r <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        par_rx_r <= bit_in;
                        state_r  <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        // Bad stop bit outranks a parity mismatch.
                        if (!bit_in) begin
                            frame_err_r <= 1'b1;
                        end else if ((PARITY_EN != 0) && (par_rx_r != expected_parity(shift_r))) begin
                            parity_err_r <= 1'b1;
                        end else begin
                            word_wr_r <= 1'b1;
                            word_r    <= shift_r;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign word_out   = word_r;
    assign word_wr    = word_wr_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed and randomized frames against a frame-level reference model, for an
// 8-bit even-parity instance and a 4-bit no-parity instance.
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       bin8, vld8, bin4, vld4;
    logic [7:0] wo8;
    logic [3:0] wo4;
    logic       wr8, pe8, fe8, busy8;
    logic       wr4, pe4, fe4, busy4;

    int n_cmp = 0;
    int n_bad = 0;
    int sel   = 0;

    logic       exp_wr, exp_pe, exp_fe, exp_busy;
    logic [7:0] exp_word8, exp_word4;

    always #5 clk = ~clk;

    serial_frame_deserializer dut8 (
        .clk(clk), .resetn(resetn), .bit_in(bin8), .bit_vld(vld8),
        .word_out(wo8), .word_wr(wr8), .parity_err(pe8), .frame_err(fe8), .busy(busy8)
    );

    serial_frame_deserializer #(.DATA_WIDTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut4 (
        .clk(clk), .resetn(resetn), .bit_in(bin4), .bit_vld(vld4),
        .word_out(wo4), .word_wr(wr4), .parity_err(pe4), .frame_err(fe4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given line values, then check the selected instance.
    task automatic step(input logic v, input logic b);
        if (sel == 0) begin
            vld8 = v; bin8 = b; vld4 = 1'b0; bin4 = 1'($urandom);
        end else begin
            vld4 = v; bin4 = b; vld8 = 1'b0; bin8 = 1'($urandom);
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            chk("word_wr8", {7'd0, wr8}, {7'd0, exp_wr});
            chk("parity_err8", {7'd0, pe8}, {7'd0, exp_pe});
            chk("frame_err8", {7'd0, fe8}, {7'd0, exp_fe});
            chk("busy8", {7'd0, busy8}, {7'd0, exp_busy});
            chk("word_out8", wo8, exp_word8);
        end else begin
            chk("word_wr4", {7'd0, wr4}, {7'd0, exp_wr});
            chk("parity_err4", {7'd0, pe4}, {7'd0, exp_pe});
            chk("frame_err4", {7'd0, fe4}, {7'd0, exp_fe});
            chk("busy4", {7'd0, busy4}, {7'd0, exp_busy});
            chk("word_out4", {4'd0, wo4}, exp_word4);
        end
    endtask

    task automatic idle(input int n, input logic b);
        exp_wr = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0;
        for (int i = 0; i < n; i++) step(b, 1'b1);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        exp_wr = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
        exp_word8 = 8'd0; exp_word4 = 8'd0;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
        resetn = 1'b1;
    endtask

    // Build the whole frame as a bit list; outcome follows from stop bit and parity.
    task automatic send_frame(input int width, input logic pen, input logic [7:0] p,
                              input logic flip, input logic stop, input int maxgap);
        logic bits[$];
        logic par;
        logic last;
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < width; i++) begin
            bits.push_back(p[i]);
            par = par ^ p[i];
        end
        if (pen) bits.push_back(par ^ flip);
        bits.push_back(stop);
        for (int i = 0; i < bits.size(); i++) begin
            exp_wr = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0;
            exp_busy = (i > 0);
            for (int g = $urandom_range(maxgap, 0); g > 0; g--) step(1'b0, 1'($urandom));
            last = (i == bits.size() - 1);
            if (last) begin
                exp_busy = 1'b0;
                if (!stop) exp_fe = 1'b1;
                else if (pen && flip) exp_pe = 1'b1;
                else begin
                    exp_wr = 1'b1;
                    if (sel == 0) exp_word8 = p;
                    else exp_word4 = p & 8'h0F;
                end
            end else begin
                exp_busy = 1'b1;
            end
            step(1'b1, bits[i]);
        end
    endtask

    initial begin
        resetn = 1'b0; bin8 = 1'b1; vld8 = 1'b0; bin4 = 1'b1; vld4 = 1'b0;
        sel = 0;
        do_reset(3);
        sel = 1;
        do_reset(1);
        sel = 0;
        idle(3, 1'b1);

        send_frame(8, 1'b1, 8'hA5, 1'b0, 1'b1, 0);
        send_frame(8, 1'b1, 8'hA5, 1'b1, 1'b1, 0);
        idle(2, 1'b0);
        send_frame(8, 1'b1, 8'h3C, 1'b1, 1'b0, 0);
        idle(1, 1'b1);
        send_frame(8, 1'b1, 8'h01, 1'b0, 1'b1, 3);
        send_frame(8, 1'b1, 8'hFF, 1'b0, 1'b1, 3);
        idle(2, 1'b1);

        exp_busy = 1'b1;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom));
        do_reset(2);
        idle(2, 1'b1);
        send_frame(8, 1'b1, 8'h5A, 1'b0, 1'b1, 1);

        for (int k = 0; k < 20; k++) begin
            send_frame(8, 1'b1, 8'($urandom), ($urandom_range(3, 0) == 0),
                       ($urandom_range(3, 0) != 0), 2);
        end
        idle(2, 1'b1);

        sel = 1;
        idle(2, 1'b1);
        send_frame(4, 1'b0, 8'h0B, 1'b0, 1'b1, 0);
        send_frame(4, 1'b0, 8'h06, 1'b0, 1'b0, 1);
        for (int k = 0; k < 10; k++) begin
            send_frame(4, 1'b0, 8'($urandom_range(15, 0)), 1'b0,
                       ($urandom_range(3, 0) != 0), 2);
        end
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
